// File: rtl/dl_rshift_arith_pkg.sv
// Shared types and helpers for the dl_rshift_arith arithmetic right shifter.
// Holds the shift-width helper and the fill-select encoding used by each barrel level.
package dl_rshift_arith_pkg;

   typedef enum logic {
      FILL_ZERO = 1'b0,
      FILL_SIGN = 1'b1
   } fill_sel_e;

   function automatic int shift_w(input int n);
      return $clog2(n);
   endfunction

   function automatic logic fill_bit(input fill_sel_e sel, input logic msb);
      logic bit_v;
      case (sel)
         FILL_SIGN: bit_v = msb;
         FILL_ZERO: bit_v = 1'b0;
         default:   bit_v = 1'b0;
      endcase
      return bit_v;
   endfunction

endpackage

// File: rtl/dl_rshift_arith_if.sv
// Operand/result bundle for dl_rshift_arith; `arith` exists only with DL_RSHIFT_ARITH_LOGICAL_EN.
// master drives operands, slave is the shifter.
interface dl_rshift_arith_if
   import dl_rshift_arith_pkg::*;
#(
   parameter int NUM_BITS = 8
);
   localparam int NUM_SHIFT_BITS = shift_w(NUM_BITS);

   logic                      in_vld;
`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
   logic                      arith;
`endif
   logic [NUM_BITS-1:0]       in;
   logic [NUM_SHIFT_BITS-1:0] shift;
   logic                      out_vld;
   logic [NUM_BITS-1:0]       out;

   modport master (
      output in_vld,
`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
      output arith,
`endif
      output in,
      output shift,
      input  out_vld,
      input  out
   );

   modport slave (
      input  in_vld,
`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
      input  arith,
`endif
      input  in,
      input  shift,
      output out_vld,
      output out
   );

endinterface

// File: rtl/dl_rshift_arith_stage.sv
// One barrel level: when enabled, shift right by DIST and fill the vacated MSBs with fill_i.
module dl_rshift_arith_stage #(
   parameter int NUM_BITS = 8,
   parameter int DIST     = 1
) (
   input  logic [NUM_BITS-1:0] data_i,
   input  logic                en_i,
   input  logic                fill_i,
   output logic [NUM_BITS-1:0] data_o
);

   // Conditional shift by the fixed distance of this level
   always_comb begin
      data_o = data_i;
      if (en_i) begin
         data_o = {{DIST{fill_i}}, data_i[NUM_BITS-1:DIST]};
      end else begin
         data_o = data_i;
      end
   end

endmodule

// File: rtl/dl_rshift_arith.sv
// Arithmetic right shifter: log2 barrel datapath, result registered one cycle after in_vld.
// Define DL_RSHIFT_ARITH_LOGICAL_EN to add the `arith` select (0 = logical / zero fill).
module dl_rshift_arith
   import dl_rshift_arith_pkg::*;
#(
   parameter int NUM_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   dl_rshift_arith_if.slave  bus
);
   localparam int NUM_SHIFT_BITS = shift_w(NUM_BITS);

   fill_sel_e           fill_sel_s;
   logic                fill_s;
   logic [NUM_BITS-1:0] res_s;
   logic [NUM_BITS-1:0] out_d, out_q;
   logic                out_vld_d, out_vld_q;

`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
   // Fill-mode select from the arith input
   always_comb begin
      fill_sel_s = FILL_SIGN;
      if (bus.arith) begin
         fill_sel_s = FILL_SIGN;
      end else begin
         fill_sel_s = FILL_ZERO;
      end
   end
`else
   assign fill_sel_s = FILL_SIGN;
`endif

   assign fill_s = fill_bit(fill_sel_s, bus.in[NUM_BITS-1]);

   // Each level sees the previous level's output; level k shifts by 2**k
   for (genvar k = 0; k < NUM_SHIFT_BITS; k++) begin : g_lvl
      logic [NUM_BITS-1:0] src_s;
      logic [NUM_BITS-1:0] dst_s;

      if (k == 0) begin : g_first
         assign src_s = bus.in;
      end else begin : g_next
         assign src_s = g_lvl[k-1].dst_s;
      end

      dl_rshift_arith_stage #(
         .NUM_BITS (NUM_BITS),
         .DIST     (2 ** k)
      ) u_stage (
         .data_i (src_s),
         .en_i   (bus.shift[k]),
         .fill_i (fill_s),
         .data_o (dst_s)
      );
   end

   assign res_s = g_lvl[NUM_SHIFT_BITS-1].dst_s;

   // Next-state: capture result on valid, otherwise hold so idle inputs never reach out
   always_comb begin
      out_vld_d = bus.in_vld;
      if (bus.in_vld) begin
         out_d = res_s;
      end else begin
         out_d = out_q;
      end
   end

   // Output register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign bus.out     = out_q;
   assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_dl_rshift_arith.sv
// Scoreboard bench for dl_rshift_arith (NUM_BITS = 8): directed vectors, idle hold,
// reset behaviour and a random stream with a mid-stream reset.
module tb_dl_rshift_arith;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [7:0] exp_q [$];
   logic       arith_s;

   dl_rshift_arith_if #(.NUM_BITS(8)) bus ();

`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
   assign bus.arith = arith_s;
`endif

   dl_rshift_arith #(.NUM_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
      logic       a;
      logic [7:0] e;
   } vec_t;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic a);
      logic signed [7:0] sd;
      logic signed [7:0] sr;
      logic [7:0]        lr;
      sd = d;
      sr = sd >>> s;
      lr = d >> s;
      return a ? sr : lr;
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic a, input logic [7:0] e);
      @(negedge clk);
      bus.in_vld = v;
      bus.in     = d;
      bus.shift  = s;
      arith_s    = a;
      if (v) exp_q.push_back(e);
   endtask

   // Monitor: pop one expected result for each valid output
   always begin
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (bus.out_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got out=%h with out_vld=1, expected no valid output", bus.out);
         end else begin
            e = exp_q.pop_front();
            check("out", bus.out, e);
         end
      end
   end

   vec_t dir_v [$];
   logic [7:0] held;
   logic       la;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      bus.in_vld = 1'b0;
      bus.in     = 8'h00;
      bus.shift  = 3'd0;
      arith_s    = 1'b1;
      #2 rst = 1'b1;

      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_vld = 1'($urandom_range(0, 1));
         bus.in     = 8'($urandom);
         bus.shift  = 3'($urandom);
         @(posedge clk);
         #1;
         check("rst_out", bus.out, 8'h00);
         check("rst_vld", {7'd0, bus.out_vld}, 8'h00);
      end
      @(negedge clk);
      bus.in_vld = 1'b0;
      rst = 1'b0;

      // Directed, back-to-back
      dir_v.push_back('{8'h96, 3'd3, 1'b1, 8'hF2});
      dir_v.push_back('{8'h7F, 3'd7, 1'b1, 8'h00});
      dir_v.push_back('{8'h80, 3'd7, 1'b1, 8'hFF});
      dir_v.push_back('{8'h5A, 3'd0, 1'b1, 8'h5A});
      dir_v.push_back('{8'hC3, 3'd1, 1'b1, 8'hE1});
      dir_v.push_back('{8'h40, 3'd2, 1'b1, 8'h10});
      dir_v.push_back('{8'hFF, 3'd4, 1'b1, 8'hFF});
      dir_v.push_back('{8'h81, 3'd0, 1'b1, 8'h81});
`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
      dir_v.push_back('{8'h96, 3'd3, 1'b0, 8'h12});
      dir_v.push_back('{8'h96, 3'd3, 1'b1, 8'hF2});
      dir_v.push_back('{8'h80, 3'd7, 1'b0, 8'h01});
      dir_v.push_back('{8'hFF, 3'd1, 1'b0, 8'h7F});
`endif
      foreach (dir_v[i]) drive(1'b1, dir_v[i].d, dir_v[i].s, dir_v[i].a, dir_v[i].e);

      // Pulse then idle: out_vld for one cycle, out holds F2
      drive(1'b1, 8'h96, 3'd3, 1'b1, 8'hF2);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'($urandom), 3'($urandom), 1'b1, 8'h00);
         @(posedge clk);
         #1;
         check("idle_vld", {7'd0, bus.out_vld}, 8'h00);
         check("idle_hold", bus.out, 8'hF2);
      end

      // Random stream with an asynchronous reset in the middle
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] d;
         logic [2:0] s;
         d = 8'($urandom);
         s = 3'($urandom);
`ifdef DL_RSHIFT_ARITH_LOGICAL_EN
         la = 1'($urandom_range(0, 1));
`else
         la = 1'b1;
`endif
         if (i == 500) begin
            drive(1'b1, 8'h80, 3'd0, 1'b1, 8'h80);
            drive(1'b1, d, s, la, model(d, s, la));
            #2 rst = 1'b1;
            #1;
            check("async_clr_out", bus.out, 8'h00);
            check("async_clr_vld", {7'd0, bus.out_vld}, 8'h00);
            exp_q.delete();
            @(negedge clk);
            bus.in_vld = 1'b0;
            @(posedge clk);
            #1;
            check("rst_hold_vld", {7'd0, bus.out_vld}, 8'h00);
            @(negedge clk);
            rst = 1'b0;
         end else begin
            drive(($urandom_range(0, 3) != 0), d, s, la, model(d, s, la));
         end
      end

      drive(1'b0, 8'h00, 3'd0, 1'b1, 8'h00);
      repeat (3) @(negedge clk);
      held = 8'(exp_q.size());
      check("queue_drained", held, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
